nla_fifo_ctrl: RTL and testbench

- Controller for the shared 32-bit BRAM sync FIFO that feeds the nonlinear approximation engine.
- Write side: round-robin arbitration of two producer streams into the single FIFO write port. A grant is held for a whole frame of FRAME_LEN data words.
- Write side also strips START_MARKER (NaN) words before they reach the FIFO.
- Read side: sequences FIFO reads under its 1-cycle read latency, presents a valid/ready stream to the engine, and flags frame ends.

---
 rtl/nla_pkg.sv | 12 +
 rtl/nla_rr_arb2.sv | 19 +
 rtl/nla_fifo_ctrl.sv | 143 ++++++++++++++
 tb/tb_nla_fifo_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nla_pkg.sv
// Shared constants and types for the nonlinear-engine FIFO controller.
package nla_pkg;

  localparam logic [31:0] NLA_START_MARKER = 32'h7F90_0000;
  localparam int          NLA_FRAME_LEN    = 16;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wr_state_e;

endpackage

// File: rtl/nla_rr_arb2.sv
// Two-input round-robin pick: returns a one-hot grant, rr_ptr_i breaks ties.
module nla_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o
);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_ptr_i ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/nla_fifo_ctrl.sv
// Write-side frame arbiter with marker stripping, and read-side sequencer for
// the 1-cycle-latency BRAM FIFO feeding the nonlinear approximation engine.
module nla_fifo_ctrl
  import nla_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                FRAME_LEN    = NLA_FRAME_LEN,
  parameter int                CNT_W        = 16,
  parameter logic [DATA_W-1:0] START_MARKER = NLA_START_MARKER
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              p0_valid_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ready_o,
  input  logic              p1_valid_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ready_o,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_wdata_o,
  input  logic              fifo_full_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  input  logic              fifo_empty_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [1:0]        grant_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  // ---------------- write side ----------------
  wr_state_e         state_q;
  logic [1:0]        grant_q;
  logic              rr_ptr_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [1:0]        arb_grant;
  logic              in_burst;
  logic              accept;
  logic              wr_fire;
  logic [DATA_W-1:0] g_data;

  nla_rr_arb2 u_arb (
    .valid_i  ({p1_valid_i, p0_valid_i}),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (arb_grant)
  );

  assign in_burst     = (state_q == W_BURST);
  assign p0_ready_o   = in_burst & grant_q[0] & ~fifo_full_i;
  assign p1_ready_o   = in_burst & grant_q[1] & ~fifo_full_i;
  assign accept       = (p0_ready_o & p0_valid_i) | (p1_ready_o & p1_valid_i);
  assign g_data       = grant_q[1] ? p1_data_i : p0_data_i;
  assign wr_fire      = accept & (g_data != START_MARKER);
  assign fifo_wr_en_o = wr_fire;
  assign fifo_wdata_o = wr_fire ? g_data : '0;
  assign grant_o      = grant_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= W_IDLE;
      grant_q  <= 2'b00;
      rr_ptr_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (|arb_grant) begin
            grant_q <= arb_grant;
            state_q <= W_BURST;
          end
        end
        W_BURST: begin
          if (wr_fire) begin
            if (wr_cnt_q == LAST_CNT) begin
              // Hand priority to the other producer and idle one cycle.
              wr_cnt_q <= '0;
              rr_ptr_q <= grant_q[0];
              grant_q  <= 2'b00;
              state_q  <= W_IDLE;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read side ----------------
  logic              rd_pend_q,  rd_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;
  logic              rd_issue;
  logic              out_fire;
  logic              rd_last;

  // Strobe is gated by reset so no read escapes while the controller is held.
  assign rd_issue = rstn_i & ~fifo_empty_i & ~rd_pend_q & (~out_valid_q | out_ready_i);
  assign out_fire = out_valid_q & out_ready_i;
  assign rd_last  = (rd_cnt_q == LAST_CNT);

  always_comb begin
    rd_pend_d   = rd_issue;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_cnt_d    = rd_cnt_q;
    if (rd_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rdata_i;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_cnt_q    <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign fifo_rd_en_o = rd_issue;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_last_o   = out_valid_q & rd_last;

endmodule

// File: tb/tb_nla_fifo_ctrl.sv
// Directed bench for nla_fifo_ctrl with a behavioural FIFO model and
// write/read scoreboards filled when stimulus is queued.
module tb_nla_fifo_ctrl;
  import nla_pkg::*;

  localparam int DATA_W = 32;
  localparam int FL     = 4;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic              p0_valid_i, p1_valid_i;
  logic [DATA_W-1:0] p0_data_i, p1_data_i;
  logic              p0_ready_o, p1_ready_o;
  logic              fifo_wr_en_o, fifo_rd_en_o;
  logic [DATA_W-1:0] fifo_wdata_o;
  logic              fifo_full_i, fifo_empty_i;
  logic [DATA_W-1:0] fifo_rdata_i;
  logic              out_valid_o, out_last_o, out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        grant_o;

  nla_fifo_ctrl #(
    .DATA_W       (DATA_W),
    .FRAME_LEN    (FL),
    .CNT_W        (16),
    .START_MARKER (NLA_START_MARKER)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .p0_valid_i   (p0_valid_i),
    .p0_data_i    (p0_data_i),
    .p0_ready_o   (p0_ready_o),
    .p1_valid_i   (p1_valid_i),
    .p1_data_i    (p1_data_i),
    .p1_ready_o   (p1_ready_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_empty_i (fifo_empty_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i),
    .grant_o      (grant_o)
  );

  always #5 clk = ~clk;

  logic [31:0] p0_q[$], p1_q[$], fifo_q[$], exp_wr[$], exp_rd[$];
  logic [1:0]  run_g[$];
  int          run_w[$];
  bit          out_ready_en = 1'b1;
  bit          full_force   = 1'b0;
  int          n_cmp = 0, n_err = 0;
  int          wr_total, out_total, p0_fires, out_idx;

  logic        s_p0_fire, s_p1_fire, s_p0_rdy, s_wr, s_rd, s_ovalid, s_last, s_out_fire;
  logic [31:0] s_wdata, s_odata;
  logic [1:0]  s_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    p0_valid_i   = (p0_q.size() != 0);
    p0_data_i    = p0_valid_i ? p0_q[0] : '0;
    p1_valid_i   = (p1_q.size() != 0);
    p1_data_i    = p1_valid_i ? p1_q[0] : '0;
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_full_i  = full_force || (fifo_q.size() >= DEPTH);
    out_ready_i  = out_ready_en;
  endtask

  task automatic push_exp(input logic [31:0] w);
    exp_wr.push_back(w);
    exp_rd.push_back(w);
  endtask

  // Called just after a falling edge: sample 1 ns before the rising edge,
  // then update the producer/FIFO models on the following falling edge.
  task automatic step();
    #4;
    s_p0_fire  = p0_valid_i & p0_ready_o;
    s_p1_fire  = p1_valid_i & p1_ready_o;
    s_p0_rdy   = p0_ready_o;
    s_wr       = fifo_wr_en_o;
    s_wdata    = fifo_wdata_o;
    s_rd       = fifo_rd_en_o;
    s_ovalid   = out_valid_o;
    s_odata    = out_data_o;
    s_last     = out_last_o;
    s_out_fire = out_valid_o & out_ready_i;
    s_grant    = grant_o;
    @(negedge clk);
    if (run_g.size() == 0 || run_g[run_g.size()-1] != s_grant) begin
      run_g.push_back(s_grant);
      run_w.push_back(0);
    end
    if (s_p0_fire) begin void'(p0_q.pop_front()); p0_fires++; end
    if (s_p1_fire) void'(p1_q.pop_front());
    if (s_rd && fifo_q.size() != 0) fifo_rdata_i = fifo_q.pop_front();
    if (s_wr) begin
      wr_total++;
      run_w[run_w.size()-1]++;
      check("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) check("wr_data", s_wdata, exp_wr.pop_front());
      fifo_q.push_back(s_wdata);
    end
    if (s_out_fire) begin
      check("out_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) check("out_data", s_odata, exp_rd.pop_front());
      check("out_last", s_last, (out_idx % FL) == FL - 1);
      out_idx++;
      out_total++;
    end
    drive();
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((p0_q.size() != 0 || p1_q.size() != 0 || fifo_q.size() != 0 ||
            exp_rd.size() != 0 || out_valid_o || grant_o != 2'b00) && n < 400) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, n < 400, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_p0_ready"}, p0_ready_o, 0);
    check({tag, "_p1_ready"}, p1_ready_o, 0);
    check({tag, "_wr_en"},    fifo_wr_en_o, 0);
    check({tag, "_wdata"},    fifo_wdata_o, 0);
    check({tag, "_rd_en"},    fifo_rd_en_o, 0);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_out_data"}, out_data_o, 0);
    check({tag, "_out_last"}, out_last_o, 0);
    check({tag, "_grant"},    grant_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g[7];
    int         exp_w[7];
    int         t_rd0, t_rd1, t_a, t_b, rd_count;
    logic [31:0] held;
    bit          have;

    // Reset state
    rstn_i = 1'b0;
    fifo_rdata_i = 32'h5555_AAAA;
    p0_q.push_back(32'h0BAD_0000);
    drive();
    #1;
    check_outputs_zero("reset");
    p0_q.delete();
    drive();
    @(negedge clk);
    @(negedge clk);
    rstn_i = 1'b1;

    // 1: priority and alternation, both producers streaming
    run_g.delete(); run_w.delete();
    for (int i = 0; i < 8; i++) p0_q.push_back(32'h1000 + i);
    for (int i = 0; i < 4; i++) p1_q.push_back(32'h2000 + i);
    for (int i = 0; i < 4; i++) push_exp(32'h1000 + i);
    for (int i = 0; i < 4; i++) push_exp(32'h2000 + i);
    for (int i = 4; i < 8; i++) push_exp(32'h1000 + i);
    drive();
    wait_drained("alt");
    exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    exp_w = '{0, 4, 0, 4, 0, 4, 0};
    check("alt_run_count", run_g.size(), 7);
    for (int i = 0; i < 7 && i < run_g.size(); i++) begin
      check($sformatf("alt_grant_%0d", i), run_g[i], exp_g[i]);
      check($sformatf("alt_writes_%0d", i), run_w[i], exp_w[i]);
    end

    // 2: START_MARKER stripped, not counted
    p0_fires = 0; wr_total = 0;
    p0_q.push_back(NLA_START_MARKER);
    for (int i = 0; i < 4; i++) begin
      p0_q.push_back(32'h3000 + i);
      push_exp(32'h3000 + i);
    end
    drive();
    wait_drained("marker");
    check("marker_ready_pulses", p0_fires, 5);
    check("marker_writes", wr_total, 4);

    // 3: fifo_full_i held for 3 cycles mid-burst
    wr_total = 0;
    for (int i = 0; i < 4; i++) begin
      p0_q.push_back(32'h4000 + i);
      push_exp(32'h4000 + i);
    end
    drive();
    for (int i = 0; i < 50 && wr_total < 2; i++) step();
    check("full_two_writes", wr_total, 2);
    full_force = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_ready", s_p0_rdy, 0);
      check("full_wr_en", s_wr, 0);
      check("full_grant", s_grant, 2'b01);
    end
    full_force = 1'b0;
    drive();
    wait_drained("full");
    check("full_total_writes", wr_total, 4);

    // 4: read latency; strobe sampled at edge t registers the word at edge t+1
    foreach (exp_g[i]) exp_g[i] = 2'b00;
    fifo_q = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
    exp_rd = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
    drive();
    t_rd0 = -1; t_rd1 = -1; t_a = -1; t_b = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_rd) begin
        if (t_rd0 < 0) t_rd0 = i;
        else if (t_rd1 < 0) t_rd1 = i;
      end
      if (s_ovalid && s_odata == 32'hA0A0_0001 && t_a < 0) t_a = i;
      if (s_ovalid && s_odata == 32'hB0B0_0002 && t_b < 0) t_b = i;
    end
    check("lat_first_read_now", t_rd0, 0);
    check("lat_A_valid", t_a - t_rd0, 2);
    check("lat_next_read", t_rd1 - t_rd0, 2);
    check("lat_B_valid", t_b - t_rd0, 4);
    wait_drained("lat");

    // 5: output stall for 5 cycles
    out_ready_en = 1'b0;
    out_total = 0;
    fifo_q = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
    exp_rd = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
    drive();
    rd_count = 0; have = 1'b0; held = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_rd) rd_count++;
      if (s_ovalid) begin
        if (!have) begin
          held = s_odata;
          have = 1'b1;
          check("stall_first_word", s_odata, 32'hE000_0000);
        end else begin
          check("stall_data_stable", s_odata, held);
        end
      end
    end
    check("stall_reads_at_most_one", rd_count <= 1, 1);
    check("stall_no_handshake", out_total, 0);
    out_ready_en = 1'b1;
    drive();
    wait_drained("stall");
    check("stall_words_out", out_total, 4);

    // 6: reset mid-burst (producer 1 owns the grant, rr_ptr = 1)
    wr_total = 0;
    for (int i = 0; i < 4; i++) begin
      p1_q.push_back(32'h6000 + i);
      push_exp(32'h6000 + i);
    end
    drive();
    for (int i = 0; i < 50 && wr_total < 2; i++) step();
    check("rst_two_writes", wr_total, 2);
    #2 rstn_i = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    p0_q.delete(); p1_q.delete(); fifo_q.delete();
    exp_wr.delete(); exp_rd.delete();
    out_idx = 0;
    fifo_rdata_i = '0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    run_g.delete(); run_w.delete();
    for (int i = 0; i < 4; i++) begin
      p0_q.push_back(32'h7000 + i);
      p1_q.push_back(32'h8000 + i);
    end
    for (int i = 0; i < 4; i++) push_exp(32'h7000 + i);
    for (int i = 0; i < 4; i++) push_exp(32'h8000 + i);
    drive();
    wait_drained("rst");
    check("rst_run_count_ok", run_g.size() >= 2, 1);
    if (run_g.size() >= 2) begin
      check("rst_first_grant", run_g[1], 2'b01);
      check("rst_first_burst_writes", run_w[1], 4);
    end
    check("rst_wr_sb_empty", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
